fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Fetch and PC-update stage of the SEQ Y86-64 processor. Sits directly upstream of the decode/write-back stage.
- Holds the PC and a byte-addressed instruction memory. Splits the instruction at PC into icode, ifun, rA, rB, valC and valP for decode.
- On each rising clock edge, selects the next PC from execute/memory feedback (Cnd, valM).
- Tracks processor status and freezes the PC on halt, invalid instruction or address error.

Parameters:
- MEM_BYTES, 1024, instruction memory size in bytes.
- ADDR_W, 10, width of the memory load address; equals log2(MEM_BYTES).
- RESET_PC, 64'd0, PC value after reset.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset; asynchronous, active-high.
- imem_we  input  1  program-load byte write enable.
- imem_waddr  input  ADDR_W  program-load byte address.
- imem_wdata  input  8  program-load byte data.
- Cnd  input  1  branch/cmov condition from execute.
- valM  input  64  memory read value; supplies the return address for ret.
- pc  output  64  current PC.
- icode  output  4  instruction code, byte0[7:4].
- ifun  output  4  function code, byte0[3:0].
- rA  output  4  register A, byte1[7:4]; 4'hF when the instruction has no register byte.
- rB  output  4  register B, byte1[3:0]; 4'hF when the instruction has no register byte.
- valC  output  64  constant word, little-endian.
- valP  output  64  PC + instruction length.
- stat  output  3  status: 1 = AOK, 2 = HLT, 3 = ADR, 4 = INS.
- halted  output  1  high once the stage is in the STOP state.
- instr_count  output  64  number of instructions retired.

Behaviour:
- Reset values (asynchronous): pc = RESET_PC, state = RUN, instr_count = 0. Memory contents are not cleared by reset; simulation initialises all bytes to 0.
- Memory write: when imem_we is high, mem[imem_waddr] <= imem_wdata at the rising edge. Writes are legal in any state and during reset. A write becomes visible to fetch on the following cycle.
- Fetch is combinational from pc (zero latency), so outputs are valid in the same cycle the PC is presented.
- Instruction length by icode:
  - 0, 1, 9: 1 byte.
  - 2, 6, A, B: 2 bytes.
  - 7, 8: 9 bytes.
  - 3, 4, 5: 10 bytes.
- Field rules:
  - need_regids for icode 2, 3, 4, 5, 6, A, B.
  - need_valC for icode 3, 4, 5, 7, 8.
  - valC is read from bytes pc+2 to pc+9 when need_regids, otherwise from pc+1 to pc+8.
  - valC = 0 when not need_valC.
- Invalid instruction (stat = INS), checked in this order:
  - icode > B.
  - icode 6 with ifun > 3.
  - icode 2 or 7 with ifun > 6.
  - any other icode with ifun != 0.
- Address error: stat = ADR if pc + len - 1 >= MEM_BYTES. When the computed length is undefined (INS), use length 1. Priority is ADR > INS > HLT > AOK.
- A 64-bit pc beyond ADDR_W is an ADR. Out-of-range bytes read as 0 and never index the array.
- valP = pc + len, 64-bit, wraps modulo 2^64.
- FSM state RUN, at each rising edge:
  - stat == AOK: pc <= new_pc and instr_count += 1.
  - new_pc = valC for call; valC for jXX when Cnd = 1; valM for ret; valP otherwise (including not-taken jXX and all cmov).
  - stat != AOK: pc is held, instr_count is not incremented, state <= STOP.
- FSM state STOP: pc and instr_count frozen, halted = 1. stat keeps showing the status decoded at the frozen pc. Only rst leaves STOP.
- Asserting rst mid-program immediately returns pc = RESET_PC, state = RUN, count = 0.
- Cnd and valM are sampled only for jXX and ret respectively; they are ignored otherwise.
- An imem write to the current pc in the same cycle does not affect that cycle's fetch.

Test Plan:
- Reset with memory filled with 0x10 (nop): pc = 0, stat = 1, halted = 0, instr_count = 0. After 3 clocks: pc = 3, count = 3.
- Bytes 30 F3 EF CD AB 89 67 45 23 01 at address 0: icode = 3, ifun = 0, rA = F, rB = 3, valC = 0x0123456789ABCDEF, valP = 10. After the edge, pc = 10.
- Bytes 74 40 00 00 00 00 00 00 00 at 0x0A: with Cnd = 1 the next pc = 0x40; with Cnd = 0 the next pc = 0x13. Byte 90 (ret) with valM = 0x20: next pc = 0x20.
- Byte 00 at pc = 5: stat = 2. After the edge, halted = 1 and pc stays 5 for 10 clocks with count frozen. Pulsing rst mid-cycle gives pc = 0 immediately.
- Byte C0 gives stat = 4. Byte 65 (opq, ifun 5) gives stat = 4. Byte 22 2A gives stat = 1 and the cmov fields decode correctly.
- irmovq placed at MEM_BYTES-5: stat = 3, PC frozen.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Purpose : SEQ Y86-64 fetch + PC-update stage with a byte-addressed instruction memory.
// Latency : fetch/decode fields are combinational from pc (zero cycles); pc, status FSM and counter update on clk.
// Backpress: none; one instruction per cycle while running, stage freezes in STOP until rst.
//
// Ports:
//   clk, rst                 - clock and asynchronous active-high reset
//   imem_we/waddr/wdata      - program-load byte write port (usable in any state, including reset)
//   Cnd, valM                - execute/memory feedback: branch condition and ret return address
//   pc                       - current program counter
//   icode, ifun, rA, rB,
//   valC, valP               - split instruction fields at pc, valP = pc + length
//   stat                     - 1 AOK, 2 HLT, 3 ADR, 4 INS for the instruction at pc
//   halted                   - high once the stage has stopped
//   instr_count              - instructions retired since reset

module fetch_pc_unit #(
    parameter int          MEM_BYTES = 1024,
    parameter int          ADDR_W    = 10,
    parameter logic [63:0] RESET_PC  = 64'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_waddr,
    input  logic [7:0]        imem_wdata,
    input  logic              Cnd,
    input  logic [63:0]       valM,
    output logic [63:0]       pc,
    output logic [3:0]        icode,
    output logic [3:0]        ifun,
    output logic [3:0]        rA,
    output logic [3:0]        rB,
    output logic [63:0]       valC,
    output logic [63:0]       valP,
    output logic [2:0]        stat,
    output logic              halted,
    output logic [63:0]       instr_count
);

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Status codes
    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_STOP = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]  r_mem [MEM_BYTES];
    state_t      r_state;
    logic [63:0] r_pc;
    logic [63:0] r_count;
    logic        r_halted;

    // ------------------------------------------------------------------
    // Instruction memory write port. No reset: program contents survive
    // rst so a program can be loaded while the core is held in reset.
    // ADDR_W = log2(MEM_BYTES), so every write address lands in the array.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (imem_we) begin
            r_mem[imem_waddr] <= imem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Byte window: the 10 bytes starting at pc (longest instruction).
    // Bytes outside the array read as 0 and never index it. Checking
    // r_pc first guarantees r_pc + k cannot overflow 64 bits.
    // ------------------------------------------------------------------
    logic [7:0] w_byte [10];

    always_comb begin
        logic [63:0] v_addr;
        v_addr = '0;
        for (int k = 0; k < 10; k++) begin
            w_byte[k] = 8'h00;
            v_addr    = r_pc + 64'(k);
            if ((r_pc < 64'(MEM_BYTES)) && (v_addr < 64'(MEM_BYTES))) begin
                w_byte[k] = r_mem[v_addr[ADDR_W-1:0]];
            end
        end
    end

    // ------------------------------------------------------------------
    // Split / classify
    // ------------------------------------------------------------------
    logic [3:0]  w_icode;
    logic [3:0]  w_ifun;
    logic        w_need_regids;
    logic        w_need_valc;
    logic [3:0]  w_len;
    logic        w_ins;
    logic [3:0]  w_len_eff;
    logic [64:0] w_last_addr;
    logic        w_adr;
    logic [63:0] w_valc_raw;
    logic [63:0] w_valc;
    logic [63:0] w_valp;
    logic [2:0]  w_stat;
    logic [63:0] w_new_pc;

    assign w_icode = w_byte[0][7:4];
    assign w_ifun  = w_byte[0][3:0];

    always_comb begin
        w_need_regids = 1'b0;
        w_need_valc   = 1'b0;
        w_len         = 4'd1;
        case (w_icode)
            I_HALT, I_NOP, I_RET: begin
                w_len = 4'd1;
            end
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
                w_need_regids = 1'b1;
                w_len         = 4'd2;
            end
            I_JXX, I_CALL: begin
                w_need_valc = 1'b1;
                w_len       = 4'd9;
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                w_need_regids = 1'b1;
                w_need_valc   = 1'b1;
                w_len         = 4'd10;
            end
            default: begin
                w_len = 4'd1;
            end
        endcase
    end

    // Invalid-instruction test in priority order; ifun limits per opcode family.
    always_comb begin
        w_ins = 1'b0;
        if (w_icode > I_POPQ) begin
            w_ins = 1'b1;
        end else if (w_icode == I_OPQ) begin
            w_ins = (w_ifun > 4'd3);
        end else if ((w_icode == I_RRMOVQ) || (w_icode == I_JXX)) begin
            w_ins = (w_ifun > 4'd6);
        end else begin
            w_ins = (w_ifun != 4'd0);
        end
    end

    // Undefined length (invalid opcode) is treated as a single byte.
    assign w_len_eff = w_ins ? 4'd1 : w_len;

    // Last byte address computed in 65 bits so a pc near 2^64 cannot wrap
    // back into the legal range.
    assign w_last_addr = {1'b0, r_pc} + 65'(w_len_eff) - 65'd1;
    assign w_adr       = (w_last_addr >= 65'(MEM_BYTES));

    assign w_valc_raw = w_need_regids
        ? {w_byte[9], w_byte[8], w_byte[7], w_byte[6], w_byte[5], w_byte[4], w_byte[3], w_byte[2]}
        : {w_byte[8], w_byte[7], w_byte[6], w_byte[5], w_byte[4], w_byte[3], w_byte[2], w_byte[1]};
    assign w_valc = w_need_valc ? w_valc_raw : 64'd0;

    // Wraps modulo 2^64 by construction.
    assign w_valp = r_pc + 64'(w_len_eff);

    always_comb begin
        if (w_adr) begin
            w_stat = S_ADR;
        end else if (w_ins) begin
            w_stat = S_INS;
        end else if (w_icode == I_HALT) begin
            w_stat = S_HLT;
        end else begin
            w_stat = S_AOK;
        end
    end

    // Next PC: Cnd only matters for jXX, valM only for ret.
    always_comb begin
        case (w_icode)
            I_CALL:  w_new_pc = w_valc;
            I_JXX:   w_new_pc = Cnd ? w_valc : w_valp;
            I_RET:   w_new_pc = valM;
            default: w_new_pc = w_valp;
        endcase
    end

    // ------------------------------------------------------------------
    // RUN/STOP control: retire on AOK, otherwise freeze and stop.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_pc     <= RESET_PC;
            r_count  <= 64'd0;
            r_halted <= 1'b0;
        end else begin
            if (r_state == ST_RUN) begin
                if (w_stat == S_AOK) begin
                    r_pc    <= w_new_pc;
                    r_count <= r_count + 64'd1;
                end else begin
                    r_state  <= ST_STOP;
                    r_halted <= 1'b1;
                end
            end
            // ST_STOP: everything held until rst.
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pc          = r_pc;
    assign icode       = w_icode;
    assign ifun        = w_ifun;
    assign rA          = w_need_regids ? w_byte[1][7:4] : 4'hF;
    assign rB          = w_need_regids ? w_byte[1][3:0] : 4'hF;
    assign valC        = w_valc;
    assign valP        = w_valp;
    assign stat        = w_stat;
    assign halted      = r_halted;
    assign instr_count = r_count;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Purpose : directed self-checking bench for fetch_pc_unit.
// Latency : checks combinational fields 1-2 ns after a rising edge, state after each edge.
// Backpress: n/a; programs are loaded while rst is held high.

module tb_fetch_pc_unit;

    logic        clk;
    logic        rst;
    logic        imem_we;
    logic [9:0]  imem_waddr;
    logic [7:0]  imem_wdata;
    logic        Cnd;
    logic [63:0] valM;
    logic [63:0] pc;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic [2:0]  stat;
    logic        halted;
    logic [63:0] instr_count;

    int n_vec = 0;
    int n_err = 0;

    fetch_pc_unit #(
        .MEM_BYTES (1024),
        .ADDR_W    (10),
        .RESET_PC  (64'd0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .Cnd         (Cnd),
        .valM        (valM),
        .pc          (pc),
        .icode       (icode),
        .ifun        (ifun),
        .rA          (rA),
        .rB          (rB),
        .valC        (valC),
        .valP        (valP),
        .stat        (stat),
        .halted      (halted),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
        $fatal(1);
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input int addr, input logic [7:0] data);
        imem_we    = 1'b1;
        imem_waddr = 10'(addr);
        imem_wdata = data;
        step();
        imem_we    = 1'b0;
    endtask

    // Bytes are packed little-endian: byte k is v[8k+7:8k].
    task automatic write_seq(input int addr, input int n, input logic [79:0] v);
        for (int k = 0; k < n; k++) write_byte(addr + k, v[8*k +: 8]);
    endtask

    task automatic fill_mem(input logic [7:0] data);
        for (int a = 0; a < 1024; a++) write_byte(a, data);
    endtask

    task automatic hold_reset();
        rst = 1'b1;
        step();
    endtask

    task automatic release_reset();
        rst = 1'b0;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        hold_reset();
        fill_mem(8'h10);
        release_reset();
        n_vec++; if (pc !== 64'd0) begin n_err++; $display("FAIL reset_pc: got %0h want 0", pc); end
        n_vec++; if (stat !== 3'd1) begin n_err++; $display("FAIL reset_stat: got %0d want 1", stat); end
        n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %0b want 0", halted); end
        n_vec++; if (instr_count !== 64'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", instr_count); end
        n_vec++; if (icode !== 4'h1 || valP !== 64'd1 || rA !== 4'hF) begin n_err++; $display("FAIL reset_nop_fields: got icode %0h valP %0h rA %0h want 1 1 f", icode, valP, rA); end
        repeat (3) step();
        n_vec++; if (pc !== 64'd3) begin n_err++; $display("FAIL nop3_pc: got %0h want 3", pc); end
        n_vec++; if (instr_count !== 64'd3) begin n_err++; $display("FAIL nop3_count: got %0d want 3", instr_count); end
    endtask

    task automatic test_irmovq_branch_ret_call();
        hold_reset();
        fill_mem(8'h10);
        write_seq(0,     10, 80'h0123456789ABCDEFF330);   // irmovq $0x0123456789ABCDEF, %rbx
        write_seq(32'hA,  9, 80'h00000000000000004074);   // jne 0x40
        write_seq(32'h13, 1, 80'h90);                     // ret
        write_seq(32'h20, 9, 80'h00000000000000010080);   // call 0x100
        release_reset();
        Cnd = 1'b1; valM = 64'hDEAD;                      // both must be ignored for irmovq
        n_vec++; if (icode !== 4'h3 || ifun !== 4'h0) begin n_err++; $display("FAIL irmovq_code: got %0h/%0h want 3/0", icode, ifun); end
        n_vec++; if (rA !== 4'hF || rB !== 4'h3) begin n_err++; $display("FAIL irmovq_regs: got %0h/%0h want f/3", rA, rB); end
        n_vec++; if (valC !== 64'h0123456789ABCDEF) begin n_err++; $display("FAIL irmovq_valC: got %0h want 123456789abcdef", valC); end
        n_vec++; if (valP !== 64'd10 || stat !== 3'd1) begin n_err++; $display("FAIL irmovq_valP_stat: got %0h/%0d want a/1", valP, stat); end
        step();
        n_vec++; if (pc !== 64'hA) begin n_err++; $display("FAIL irmovq_next_pc: got %0h want a", pc); end
        n_vec++; if (icode !== 4'h7 || ifun !== 4'h4 || valC !== 64'h40 || valP !== 64'h13 || rA !== 4'hF) begin n_err++; $display("FAIL jxx_fields: got %0h %0h %0h %0h %0h want 7 4 40 13 f", icode, ifun, valC, valP, rA); end
        step();
        n_vec++; if (pc !== 64'h40) begin n_err++; $display("FAIL jxx_taken_pc: got %0h want 40", pc); end
        // Rerun with branch not taken, landing on ret.
        hold_reset();
        release_reset();
        Cnd = 1'b0;
        step();
        step();
        n_vec++; if (pc !== 64'h13) begin n_err++; $display("FAIL jxx_not_taken_pc: got %0h want 13", pc); end
        n_vec++; if (icode !== 4'h9 || valP !== 64'h14 || rB !== 4'hF || valC !== 64'd0) begin n_err++; $display("FAIL ret_fields: got %0h %0h %0h %0h want 9 14 f 0", icode, valP, rB, valC); end
        valM = 64'h20;
        step();
        n_vec++; if (pc !== 64'h20 || instr_count !== 64'd3) begin n_err++; $display("FAIL ret_pc: got %0h cnt %0d want 20 cnt 3", pc, instr_count); end
        n_vec++; if (icode !== 4'h8 || valC !== 64'h100 || valP !== 64'h29) begin n_err++; $display("FAIL call_fields: got %0h %0h %0h want 8 100 29", icode, valC, valP); end
        valM = 64'h77;
        step();
        n_vec++; if (pc !== 64'h100 || instr_count !== 64'd4) begin n_err++; $display("FAIL call_pc: got %0h cnt %0d want 100 cnt 4", pc, instr_count); end
    endtask

    task automatic test_halt();
        hold_reset();
        fill_mem(8'h10);
        write_byte(5, 8'h00);
        release_reset();
        repeat (5) step();
        n_vec++; if (pc !== 64'd5 || instr_count !== 64'd5) begin n_err++; $display("FAIL halt_reach: got pc %0h cnt %0d want 5 5", pc, instr_count); end
        n_vec++; if (stat !== 3'd2 || halted !== 1'b0) begin n_err++; $display("FAIL halt_stat: got %0d/%0b want 2/0", stat, halted); end
        step();
        n_vec++; if (halted !== 1'b1 || pc !== 64'd5 || instr_count !== 64'd5) begin n_err++; $display("FAIL halt_stop: got %0b %0h %0d want 1 5 5", halted, pc, instr_count); end
        repeat (10) step();
        n_vec++; if (halted !== 1'b1 || pc !== 64'd5 || instr_count !== 64'd5 || stat !== 3'd2) begin n_err++; $display("FAIL halt_frozen: got %0b %0h %0d %0d want 1 5 5 2", halted, pc, instr_count, stat); end
        // Overwrite the halt byte: old byte still fetched this cycle, STOP persists after.
        imem_we = 1'b1; imem_waddr = 10'd5; imem_wdata = 8'h10;
        #1;
        n_vec++; if (stat !== 3'd2) begin n_err++; $display("FAIL same_cycle_write: got stat %0d want 2", stat); end
        step();
        imem_we = 1'b0;
        n_vec++; if (stat !== 3'd1 || pc !== 64'd5 || halted !== 1'b1) begin n_err++; $display("FAIL stop_sticky: got %0d %0h %0b want 1 5 1", stat, pc, halted); end
        // Asynchronous reset pulse in the middle of a cycle.
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if (pc !== 64'd0 || instr_count !== 64'd0 || halted !== 1'b0) begin n_err++; $display("FAIL async_rst: got %0h %0d %0b want 0 0 0", pc, instr_count, halted); end
        rst = 1'b0;
    endtask

    task automatic test_invalid();
        hold_reset();
        write_byte(0, 8'hC0);
        release_reset();
        n_vec++; if (stat !== 3'd4 || valP !== 64'd1) begin n_err++; $display("FAIL ins_c0: got stat %0d valP %0h want 4 1", stat, valP); end
        step();
        n_vec++; if (halted !== 1'b1 || pc !== 64'd0 || instr_count !== 64'd0) begin n_err++; $display("FAIL ins_stop: got %0b %0h %0d want 1 0 0", halted, pc, instr_count); end
        hold_reset();
        write_byte(0, 8'h65);
        release_reset();
        n_vec++; if (stat !== 3'd4) begin n_err++; $display("FAIL ins_opq5: got %0d want 4", stat); end
        hold_reset();
        write_byte(0, 8'h01);
        release_reset();
        n_vec++; if (stat !== 3'd4) begin n_err++; $display("FAIL ins_nop_ifun1: got %0d want 4", stat); end
        hold_reset();
        write_byte(0, 8'h22);
        write_byte(1, 8'h2A);
        release_reset();
        Cnd = 1'b1;
        n_vec++; if (stat !== 3'd1 || icode !== 4'h2 || ifun !== 4'h2) begin n_err++; $display("FAIL cmov_code: got %0d %0h %0h want 1 2 2", stat, icode, ifun); end
        n_vec++; if (rA !== 4'h2 || rB !== 4'hA || valC !== 64'd0 || valP !== 64'd2) begin n_err++; $display("FAIL cmov_fields: got %0h %0h %0h %0h want 2 a 0 2", rA, rB, valC, valP); end
        step();
        n_vec++; if (pc !== 64'd2 || instr_count !== 64'd1) begin n_err++; $display("FAIL cmov_next_pc: got %0h %0d want 2 1", pc, instr_count); end
    endtask

    task automatic test_addr_error();
        hold_reset();
        fill_mem(8'h10);
        write_seq(0, 9, 80'h00000000000003FB70);          // jmp 1019
        write_byte(1019, 8'h30);
        write_byte(1020, 8'hF3);
        release_reset();
        Cnd = 1'b1;
        step();
        n_vec++; if (pc !== 64'd1019 || instr_count !== 64'd1) begin n_err++; $display("FAIL adr_reach: got %0h %0d want 3fb 1", pc, instr_count); end
        n_vec++; if (stat !== 3'd3 || icode !== 4'h3 || rB !== 4'h3) begin n_err++; $display("FAIL adr_stat: got %0d %0h %0h want 3 3 3", stat, icode, rB); end
        n_vec++; if (valC !== 64'h101010 || valP !== 64'd1029) begin n_err++; $display("FAIL adr_oob_bytes: got valC %0h valP %0d want 101010 1029", valC, valP); end
        step();
        n_vec++; if (halted !== 1'b1 || pc !== 64'd1019 || instr_count !== 64'd1) begin n_err++; $display("FAIL adr_frozen: got %0b %0h %0d want 1 3fb 1", halted, pc, instr_count); end
        // Last byte of memory is still addressable.
        hold_reset();
        write_seq(0, 9, 80'h00000000000003FF70);
        write_byte(1023, 8'h00);
        release_reset();
        step();
        n_vec++; if (pc !== 64'h3FF || stat !== 3'd2) begin n_err++; $display("FAIL last_byte: got pc %0h stat %0d want 3ff 2", pc, stat); end
        // Just past the array.
        hold_reset();
        write_seq(0, 9, 80'h00000000000004007);
        write_seq(0, 9, 80'h00000000000000040070);
        release_reset();
        step();
        n_vec++; if (pc !== 64'h400 || stat !== 3'd3 || icode !== 4'h0) begin n_err++; $display("FAIL past_end: got %0h %0d %0h want 400 3 0", pc, stat, icode); end
        // Top of the 64-bit space: bytes read 0, valP wraps to 0.
        hold_reset();
        write_seq(0, 9, 80'h00FFFFFFFFFFFFFFFF70);
        release_reset();
        step();
        n_vec++; if (pc !== 64'hFFFFFFFFFFFFFFFF || stat !== 3'd3 || valP !== 64'd0) begin n_err++; $display("FAIL pc_max: got %0h %0d valP %0h want ffffffffffffffff 3 0", pc, stat, valP); end
    endtask

    initial begin
        rst        = 1'b1;
        imem_we    = 1'b0;
        imem_waddr = '0;
        imem_wdata = '0;
        Cnd        = 1'b0;
        valM       = '0;
        test_reset();
        test_irmovq_branch_ret_call();
        test_halt();
        test_invalid();
        test_addr_error();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
